// File: rtl/score_keeper.sv
// Snake game score keeper: counts apples, ranks the high score on game over,
// and renders both values as blanked decimal on six active-low 7-seg displays.
module score_keeper (
  input  logic       clk,
  input  logic       rst,
  input  logic       apple_eaten,
  input  logic       collision,
  output logic [7:0] score,
  output logic [7:0] high_score,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic [6:0] hex4,
  output logic [6:0] hex5
);

  localparam int unsigned VAL_W = 8;
  localparam int unsigned SEG_W = 7;
  localparam logic [VAL_W-1:0] SCORE_MAX = 8'hFF;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {PLAYING, OVER} state_t;

  state_t state;

  // Game state, score and high score; collision takes priority over an apple.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= PLAYING;
      score      <= '0;
      high_score <= '0;
    end else begin
      case (state)
        PLAYING: begin
          if (collision) begin
            state <= OVER;
            if (score > high_score) high_score <= score;
          end else if (apple_eaten && score != SCORE_MAX) begin
            score <= score + 8'd1;
          end
        end
        OVER: begin
          if (!collision) begin
            state <= PLAYING;
            score <= '0;
          end
        end
        default: state <= PLAYING;
      endcase
    end
  end

  // Double-dabble: 8-bit binary to three BCD digits {hundreds, tens, units}.
  function automatic logic [11:0] to_bcd(input logic [VAL_W-1:0] bin);
    logic [19:0] sh;
    sh = {12'd0, bin};
    for (int i = 0; i < 8; i++) begin
      if (sh[11:8]  >= 4'd5) sh[11:8]  = sh[11:8]  + 4'd3;
      if (sh[15:12] >= 4'd5) sh[15:12] = sh[15:12] + 4'd3;
      if (sh[19:16] >= 4'd5) sh[19:16] = sh[19:16] + 4'd3;
      sh = sh << 1;
    end
    return sh[19:8];
  endfunction

  function automatic logic [SEG_W-1:0] to_seg(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

  logic [11:0] score_bcd;
  logic [11:0] high_bcd;

  assign score_bcd = to_bcd(score);
  assign high_bcd  = to_bcd(high_score);

  // Leading-zero blanking on hundreds and tens; units always shown.
  assign hex0 = to_seg(score_bcd[3:0]);
  assign hex1 = (score < 8'd10)  ? SEG_BLANK : to_seg(score_bcd[7:4]);
  assign hex2 = (score < 8'd100) ? SEG_BLANK : to_seg(score_bcd[11:8]);
  assign hex3 = to_seg(high_bcd[3:0]);
  assign hex4 = (high_score < 8'd10)  ? SEG_BLANK : to_seg(high_bcd[7:4]);
  assign hex5 = (high_score < 8'd100) ? SEG_BLANK : to_seg(high_bcd[11:8]);

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: behavioural model feeds a scoreboard queue,
// DUT outputs are popped and checked one cycle after each driven step.
module tb_score_keeper;

  logic       clk = 1'b0;
  logic       rst;
  logic       apple_eaten;
  logic       collision;
  logic [7:0] score;
  logic [7:0] high_score;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;

  score_keeper dut (
    .clk(clk), .rst(rst), .apple_eaten(apple_eaten), .collision(collision),
    .score(score), .high_score(high_score),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] s;
    logic [7:0] h;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  logic [7:0] m_score;
  logic [7:0] m_high;
  logic       m_over;

  function automatic logic [6:0] ref_seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Reference digit rendering by division, pos 0=units 1=tens 2=hundreds.
  function automatic logic [6:0] ref_hex(input logic [7:0] v, input int pos);
    int n;
    n = int'(v);
    if (pos == 0) return ref_seg(n % 10);
    if (pos == 1) return (n < 10) ? 7'b1111111 : ref_seg((n / 10) % 10);
    return (n < 100) ? 7'b1111111 : ref_seg(n / 100);
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_disp(input string tag);
    check({tag, "_hex0"}, 8'(hex0), 8'(ref_hex(m_score, 0)));
    check({tag, "_hex1"}, 8'(hex1), 8'(ref_hex(m_score, 1)));
    check({tag, "_hex2"}, 8'(hex2), 8'(ref_hex(m_score, 2)));
    check({tag, "_hex3"}, 8'(hex3), 8'(ref_hex(m_high, 0)));
    check({tag, "_hex4"}, 8'(hex4), 8'(ref_hex(m_high, 1)));
    check({tag, "_hex5"}, 8'(hex5), 8'(ref_hex(m_high, 2)));
  endtask

  // Drive one cycle, advance the model, then compare after the edge.
  task automatic step(input logic a, input logic c, input string tag);
    exp_t e;
    @(negedge clk);
    apple_eaten = a;
    collision   = c;
    if (!m_over) begin
      if (c) begin
        if (m_score > m_high) m_high = m_score;
        m_over = 1'b1;
      end else if (a && m_score != 8'hFF) begin
        m_score = m_score + 8'd1;
      end
    end else if (!c) begin
      m_over  = 1'b0;
      m_score = 8'd0;
    end
    exp_q.push_back('{s: m_score, h: m_high});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, "_score"}, score, e.s);
    check({tag, "_high"}, high_score, e.h);
  endtask

  // Asynchronous reset between edges, checked before the next edge.
  task automatic async_reset(input string tag);
    @(negedge clk);
    apple_eaten = 1'b0;
    collision   = 1'b0;
    #2;
    rst = 1'b0;
    m_score = 8'd0;
    m_high  = 8'd0;
    m_over  = 1'b0;
    #1;
    check({tag, "_score"}, score, 8'd0);
    check({tag, "_high"}, high_score, 8'd0);
    check_disp(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    apple_eaten = 1'b0;
    collision = 1'b0;
    m_score = 8'd0;
    m_high  = 8'd0;
    m_over  = 1'b0;
    #12;
    check("por_score", score, 8'd0);
    check("por_high", high_score, 8'd0);
    check("por_hex0", 8'(hex0), 8'(7'b1000000));
    check("por_hex1", 8'(hex1), 8'(7'b1111111));
    check_disp("por");
    @(negedge clk);
    rst = 1'b1;

    // Held pulse of 4 plus 3 single pulses reaches 7, then mid-count reset.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, "held");
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, "pulse");
      step(1'b0, 1'b0, "gap");
    end
    check("pre_reset_score", score, 8'd7);
    async_reset("midreset");

    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, "count");
      step(1'b0, 1'b0, "count_gap");
    end
    check("c12_hex0", 8'(hex0), 8'(7'b0100100));
    check("c12_hex1", 8'(hex1), 8'(7'b1111001));
    check("c12_hex2", 8'(hex2), 8'(7'b1111111));
    check_disp("c12");

    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, "over");
    check("over_hex3", 8'(hex3), 8'(7'b0100100));
    check("over_hex4", 8'(hex4), 8'(7'b1111001));
    check_disp("over");

    step(1'b1, 1'b0, "restart");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, "low");
    step(1'b0, 1'b1, "low_over");
    check("low_high", high_score, 8'd12);
    step(1'b0, 1'b0, "low_restart");

    async_reset("reset2");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, "four");
    step(1'b1, 1'b1, "simul");
    check("simul_score", score, 8'd4);
    check("simul_high", high_score, 8'd4);
    step(1'b0, 1'b0, "simul_restart");

    for (int i = 0; i < 260; i++) step(1'b1, 1'b0, "sat");
    check("sat_score", score, 8'd255);
    check("sat_hex2", 8'(hex2), 8'(7'b0100100));
    check("sat_hex1", 8'(hex1), 8'(7'b0010010));
    check("sat_hex0", 8'(hex0), 8'(7'b0010010));
    check_disp("sat");
    step(1'b0, 1'b1, "sat_over");
    check("sat_high", high_score, 8'd255);
    check_disp("sat_over");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
